// File: rtl/video_sync_decoder_if.sv
// Composite video sync decoder bus: ADC sample in, recovered timing out.
interface video_sync_decoder_if;
  localparam int unsigned LVL_W  = 5;
  localparam int unsigned PIX_W  = 11;
  localparam int unsigned LINE_W = 10;

  logic [LVL_W-1:0]  analogValue;
  logic              hsync;
  logic              newFrame;
  logic [PIX_W-1:0]  pixelX;
  logic [LINE_W-1:0] lineY;
  logic              inSync;
  logic              locked;

  // Video source side: supplies samples, observes timing.
  modport master (
    output analogValue,
    input  hsync, newFrame, pixelX, lineY, inSync, locked
  );

  // Decoder side.
  modport slave (
    input  analogValue,
    output hsync, newFrame, pixelX, lineY, inSync, locked
  );
endinterface

// File: rtl/video_sync_decoder.sv
// Composite video sync decoder: slices sync from a 5-bit sample stream,
// classifies low pulses (line / broad / equalising), and recovers hsync,
// new-frame strobes, pixel/line counters and a line-timing lock flag.
// Optional: define SYNC_GLITCH_FILTER_EN for a 2-sample agreement filter on
// the sliced sync level (adds one cycle of strobe latency).
module video_sync_decoder #(
  parameter int unsigned SYNC_THRESHOLD = 4,
  parameter int unsigned HS_MIN         = 48,
  parameter int unsigned HS_MAX         = 110,
  parameter int unsigned BROAD_MIN      = 300,
  parameter int unsigned BROAD_COUNT    = 3,
  parameter int unsigned LINE_NOM       = 1024,
  parameter int unsigned LINE_TOL       = 32,
  parameter int unsigned LOCK_LINES     = 8,
  parameter int unsigned TIMEOUT        = 2047
) (
  input logic                  clk,
  input logic                  rst,
  video_sync_decoder_if.slave  bus
);

  localparam int unsigned LVL_W  = 5;
  localparam int unsigned LOW_W  = 10;
  localparam int unsigned PIX_W  = 11;
  localparam int unsigned LINE_W = 10;
  localparam int unsigned PER_W  = 12;
  localparam int unsigned BRD_W  = $clog2(BROAD_COUNT + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_LINES + 1);

  localparam logic [LVL_W-1:0]  THRESH      = LVL_W'(SYNC_THRESHOLD);
  localparam logic [LOW_W-1:0]  LOW_MAX     = '1;
  localparam logic [LOW_W-1:0]  HS_LO       = LOW_W'(HS_MIN);
  localparam logic [LOW_W-1:0]  HS_HI       = LOW_W'(HS_MAX);
  localparam logic [LOW_W-1:0]  BROAD_LO    = LOW_W'(BROAD_MIN);
  localparam logic [PIX_W-1:0]  PIX_MAX     = '1;
  localparam logic [PIX_W-1:0]  PIX_TIMEOUT = PIX_W'(TIMEOUT);
  localparam logic [LINE_W-1:0] LINE_MAX    = '1;
  localparam logic [PER_W-1:0]  PER_LO      = PER_W'(LINE_NOM - LINE_TOL);
  localparam logic [PER_W-1:0]  PER_HI      = PER_W'(LINE_NOM + LINE_TOL);
  localparam logic [BRD_W-1:0]  BRD_FULL    = BRD_W'(BROAD_COUNT);
  localparam logic [BRD_W-1:0]  BRD_LAST    = BRD_W'(BROAD_COUNT - 1);
  localparam logic [GOOD_W-1:0] GOOD_FULL   = GOOD_W'(LOCK_LINES);

  logic              raw_sync;
  logic              lvl_next, lvl_valid_next;
  logic              sync_lvl, sync_prev, lvl_valid, pulse_valid;
  logic [LOW_W-1:0]  low_cnt;
  logic              pulse_end, is_line, is_broad, period_ok, timeout;
  logic [PER_W-1:0]  period;
  logic [PIX_W-1:0]  pixel_next;
  logic              line_sync, frame_strobe, lock_flag, armed;
  logic [PIX_W-1:0]  pixel_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic [BRD_W-1:0]  broad_cnt;
  logic [GOOD_W-1:0] good_cnt;

  assign raw_sync = (bus.analogValue < THRESH);

`ifdef SYNC_GLITCH_FILTER_EN
  logic raw_prev, raw_seen;

  // Previous raw compare result, for the 2-sample agreement filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_prev <= 1'b0;
      raw_seen <= 1'b0;
    end else begin
      raw_prev <= raw_sync;
      raw_seen <= 1'b1;
    end
  end

  // Level only moves once two consecutive raw results agree.
  always_comb begin
    lvl_next       = sync_lvl;
    lvl_valid_next = lvl_valid;
    if (raw_seen && (raw_sync == raw_prev)) begin
      lvl_next       = raw_sync;
      lvl_valid_next = 1'b1;
    end
  end
`else
  // Unfiltered: the level follows the raw compare every cycle.
  always_comb begin
    lvl_next       = raw_sync;
    lvl_valid_next = 1'b1;
  end
`endif

  // Sync level register and low-pulse width counter; a pulse only counts if
  // a genuine above-threshold level was seen just before it started.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_lvl    <= 1'b0;
      sync_prev   <= 1'b0;
      lvl_valid   <= 1'b0;
      pulse_valid <= 1'b0;
      low_cnt     <= '0;
    end else begin
      sync_lvl  <= lvl_next;
      sync_prev <= sync_lvl;
      lvl_valid <= lvl_valid_next;
      if (lvl_next) begin
        if (!sync_lvl) begin
          low_cnt     <= LOW_W'(1);
          pulse_valid <= lvl_valid;
        end else if (low_cnt != LOW_MAX) begin
          low_cnt <= low_cnt + LOW_W'(1);
        end
      end
    end
  end

  // Pulse-end classification and line period measurement.
  always_comb begin
    pulse_end = sync_prev && !sync_lvl && pulse_valid;
    is_line   = pulse_end && (low_cnt >= HS_LO) && (low_cnt <= HS_HI);
    is_broad  = pulse_end && (low_cnt >= BROAD_LO);
    period    = PER_W'(pixel_cnt) + PER_W'(1);
    period_ok = (period >= PER_LO) && (period <= PER_HI);
    if (is_line) begin
      pixel_next = '0;
    end else if (pixel_cnt == PIX_MAX) begin
      pixel_next = pixel_cnt;
    end else begin
      pixel_next = pixel_cnt + PIX_W'(1);
    end
    timeout = !is_line && (pixel_next == PIX_TIMEOUT);
  end

  // Strobes, counters and lock tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_sync    <= 1'b0;
      frame_strobe <= 1'b0;
      pixel_cnt    <= '0;
      line_cnt     <= '0;
      broad_cnt    <= '0;
      good_cnt     <= '0;
      armed        <= 1'b0;
      lock_flag    <= 1'b0;
    end else begin
      line_sync    <= is_line;
      frame_strobe <= is_broad && (broad_cnt == BRD_LAST);
      pixel_cnt    <= pixel_next;
      lock_flag    <= (good_cnt == GOOD_FULL) && !timeout;

      if (is_line) begin
        broad_cnt <= '0;
        if (line_cnt != LINE_MAX) line_cnt <= line_cnt + LINE_W'(1);
      end else if (is_broad) begin
        if (broad_cnt != BRD_FULL) broad_cnt <= broad_cnt + BRD_W'(1);
        if (broad_cnt == BRD_LAST) line_cnt <= '0;
      end

      if (is_line) begin
        if (!armed) begin
          armed <= 1'b1;
        end else if (period_ok) begin
          if (good_cnt != GOOD_FULL) good_cnt <= good_cnt + GOOD_W'(1);
        end else begin
          good_cnt <= '0;
        end
      end else if (timeout) begin
        good_cnt <= '0;
        armed    <= 1'b0;
      end
    end
  end

  assign bus.hsync    = line_sync;
  assign bus.newFrame = frame_strobe;
  assign bus.pixelX   = pixel_cnt;
  assign bus.lineY    = line_cnt;
  assign bus.inSync   = sync_lvl;
  assign bus.locked   = lock_flag;

endmodule

// File: tb/tb_video_sync_decoder.sv
// Directed bench for video_sync_decoder: line lock, PAL field, width limits,
// lock loss/timeout, reset mid-pulse and single-sample spikes.
module tb_video_sync_decoder;

`ifdef SYNC_GLITCH_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic rst;

  video_sync_decoder_if bus ();

  video_sync_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int n_hs = 0;
  int n_nf = 0;
  int hs_cyc = 0;
  int hs_period = 0;
  int px_before_hs = 0;
  int prev_px = 0;
  int nf_cyc = 0;
  int ly_at_nf = -1;
  int lock_rise_hs = -1;
  int lock_fall_dly = -1;
  logic prev_lock = 1'b0;
  int last_end = 0;
  logic any_sync = 1'b0;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one sample, advance one clock, then record strobe events.
  task automatic step(input logic [4:0] v);
    bus.analogValue = v;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.inSync) any_sync = 1'b1;
    if (bus.hsync) begin
      n_hs++;
      hs_period    = cyc - hs_cyc;
      hs_cyc       = cyc;
      px_before_hs = prev_px;
    end
    if (bus.newFrame) begin
      n_nf++;
      nf_cyc   = cyc;
      ly_at_nf = int'(bus.lineY);
    end
    if (bus.locked && !prev_lock) lock_rise_hs = n_hs;
    if (!bus.locked && prev_lock) lock_fall_dly = cyc - hs_cyc;
    prev_lock = bus.locked;
    prev_px   = int'(bus.pixelX);
  endtask

  // One low pulse of width w followed by high level up to the given period.
  task automatic pulse(input int w, input int period);
    for (int i = 0; i < w; i++) step(5'd0);
    last_end = cyc;
    for (int i = w; i < period; i++) step(5'd20);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hsync"},    32'(bus.hsync),    32'd0);
    check({tag, "_newFrame"}, 32'(bus.newFrame), 32'd0);
    check({tag, "_pixelX"},   32'(bus.pixelX),   32'd0);
    check({tag, "_lineY"},    32'(bus.lineY),    32'd0);
    check({tag, "_inSync"},   32'(bus.inSync),   32'd0);
    check({tag, "_locked"},   32'(bus.locked),   32'd0);
  endtask

  initial begin
    int base_hs;
    int base_nf;
    int ly_hold;
    int brd3_end;
    logic seen46;
    logic seen47;
    int widths [5];
    int exp_hs [5];
    widths = '{47, 48, 110, 111, 299};
    exp_hs = '{0, 1, 1, 0, 0};

    // Reset state
    rst = 1'b1;
    bus.analogValue = 5'd20;
    for (int i = 0; i < 3; i++) step(5'd20);
    check_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 100; i++) step(5'd20);

    // Ten nominal lines: latency, period, pixel count, lock on the 9th hsync
    base_hs = n_hs;
    pulse(75, 1024);
    check("first_hs_latency", 32'(hs_cyc - last_end), 32'(LAT));
    for (int l = 1; l < 10; l++) pulse(75, 1024);
    check("lines_hs_count", 32'(n_hs - base_hs), 32'd10);
    check("lines_period", 32'(hs_period), 32'd1024);
    check("lines_px_before_hs", 32'(px_before_hs), 32'd1023);
    check("lock_rise_hs", 32'(lock_rise_hs), 32'd9);
    check("lines_locked", 32'(bus.locked), 32'd1);
    check("lines_lineY", 32'(bus.lineY), 32'd10);

    // One long line drops lock; eight good periods re-lock
    pulse(75, 1100);
    pulse(75, 1024);
    check("long_period", 32'(hs_period), 32'd1100);
    check("long_unlock_dly", 32'(lock_fall_dly), 32'd1);
    check("long_locked", 32'(bus.locked), 32'd0);
    for (int l = 1; l < 8; l++) pulse(75, 1024);
    check("relock_7good", 32'(bus.locked), 32'd0);
    pulse(75, 1024);
    check("relock_8good", 32'(bus.locked), 32'd1);

    // Loss of signal: timeout at pixelX saturation
    ly_hold = int'(bus.lineY);
    seen46 = 1'b0;
    seen47 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step(5'd20);
      if (!seen46 && bus.pixelX == 11'd2046) begin
        seen46 = 1'b1;
        check("timeout_locked_2046", 32'(bus.locked), 32'd1);
      end
      if (!seen47 && bus.pixelX == 11'd2047) begin
        seen47 = 1'b1;
        check("timeout_locked_2047", 32'(bus.locked), 32'd0);
      end
    end
    check("timeout_seen", 32'({seen46, seen47}), 32'd3);
    check("timeout_pixelX_sat", 32'(bus.pixelX), 32'd2047);
    check("timeout_lineY_hold", 32'(bus.lineY), 32'(ly_hold));

    // PAL field: 5 equalising, 5 broad, 5 equalising, then lines
    base_nf = n_nf;
    brd3_end = 0;
    for (int i = 0; i < 5; i++) pulse(38, 512);
    for (int i = 0; i < 5; i++) begin
      pulse(437, 512);
      if (i == 2) brd3_end = last_end;
    end
    for (int i = 0; i < 5; i++) pulse(38, 512);
    check("pal_nf_count", 32'(n_nf - base_nf), 32'd1);
    check("pal_nf_timing", 32'(nf_cyc - brd3_end), 32'(LAT));
    check("pal_lineY_at_nf", 32'(ly_at_nf), 32'd0);
    check("pal_lineY_pre", 32'(bus.lineY), 32'd0);
    pulse(75, 1024);
    check("pal_lineY_1", 32'(bus.lineY), 32'd1);
    for (int l = 0; l < 3; l++) pulse(75, 1024);
    check("pal_lineY_4", 32'(bus.lineY), 32'd4);

    // Width boundaries for line sync
    for (int k = 0; k < 5; k++) begin
      base_hs = n_hs;
      pulse(widths[k], 1024);
      check($sformatf("width%0d_hs", widths[k]), 32'(n_hs - base_hs), 32'(exp_hs[k]));
    end

    // Non-line, non-broad widths leave the broad count alone
    base_nf = n_nf;
    pulse(437, 512);
    pulse(437, 512);
    check("broad2_no_nf", 32'(n_nf - base_nf), 32'd0);
    pulse(47, 512);
    pulse(111, 512);
    pulse(299, 512);
    check("others_no_nf", 32'(n_nf - base_nf), 32'd0);
    pulse(437, 512);
    check("broad3_nf", 32'(n_nf - base_nf), 32'd1);
    check("broad3_lineY", 32'(bus.lineY), 32'd0);

    // Single-sample spike on a high line
    base_hs = n_hs;
    base_nf = n_nf;
    any_sync = 1'b0;
    pulse(1, 1024);
    check("spike_hs", 32'(n_hs - base_hs), 32'd0);
    check("spike_nf", 32'(n_nf - base_nf), 32'd0);
`ifdef SYNC_GLITCH_FILTER_EN
    check("spike_inSync", 32'(any_sync), 32'd0);
`endif

    // Reset 60 clocks into a 75-clock pulse
    base_hs = n_hs;
    for (int i = 0; i < 60; i++) step(5'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(5'd0);
    check_all_zero("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 11; i++) step(5'd0);
    check("rst_mid_inSync", 32'(bus.inSync), 32'd1);
    for (int i = 0; i < 949; i++) step(5'd20);
    check("rst_mid_no_hs", 32'(n_hs - base_hs), 32'd0);
    pulse(75, 1024);
    check("rst_mid_next_hs", 32'(n_hs - base_hs), 32'd1);
    check("rst_mid_lineY", 32'(bus.lineY), 32'd1);

    // Reset early in a pulse: remaining width would look like a line sync
    base_hs = n_hs;
    for (int i = 0; i < 5; i++) step(5'd0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) step(5'd0);
    rst = 1'b0;
    for (int i = 0; i < 68; i++) step(5'd0);
    for (int i = 0; i < 949; i++) step(5'd20);
    check("rst_early_no_hs", 32'(n_hs - base_hs), 32'd0);
    check("rst_early_lineY", 32'(bus.lineY), 32'd0);
    pulse(75, 1024);
    check("rst_early_next_hs", 32'(n_hs - base_hs), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_sync_decoder.md
Name: video_sync_decoder

Overview:
- Receive-side counterpart of the composite video generator: digitised incoming composite video (5-bit level from an external ADC or resistor-ladder comparator bank) in, video timing recovered.
- Slices sync from the signal, classifies low pulses as line sync, broad (vertical) or equalising, and emits hsync / new-frame strobes, pixel and line counters, and a lock flag.
- Feeds the OSD overlay path so generated graphics align with camera video. Defaults assume the 16 MHz clock and PAL timing (64 us line = 1024 clocks).

Parameters:
- SYNC_THRESHOLD, 4: a sample strictly below this level is sync (5-bit compare).
- HS_MIN, 48: minimum low-pulse width, in clocks, classified as line sync.
- HS_MAX, 110: maximum low-pulse width classified as line sync.
- BROAD_MIN, 300: minimum low-pulse width classified as a broad (vertical) pulse.
- BROAD_COUNT, 3: number of consecutive broad pulses that declare a new field.
- LINE_NOM, 1024: nominal line period in clocks.
- LINE_TOL, 32: allowed deviation from LINE_NOM, +/-, inclusive.
- LOCK_LINES, 8: consecutive good line periods needed to assert lock.
- TIMEOUT, 2047: clocks without hsync before lock drops.

Ports:
- clk, input, 1: system clock (16 MHz).
- rst, input, 1: synchronous, active-high reset.
- analogValue, input, 5: digitised composite video sample, one per clock.
- hsync, output, 1: one-cycle strobe at the end of a valid line-sync pulse.
- newFrame, output, 1: one-cycle strobe when a field's vertical sync is recognised.
- pixelX, output, 11: clocks since the last hsync strobe; saturates at 2047.
- lineY, output, 10: hsync count since the last newFrame; saturates at 1023.
- inSync, output, 1: level, high while the registered sample is below threshold.
- locked, output, 1: line timing is stable.

Behaviour:
- Reset: all outputs 0; internal counters 0; broad counter 0; good-line counter 0.
- Stage 1: syncLvl is registered each cycle as (analogValue < SYNC_THRESHOLD). inSync = syncLvl.
- lowCnt:
  - Clears to 1 on the first cycle of syncLvl=1.
  - Increments while syncLvl=1 and saturates at 1023.
- Pulse end: the cycle syncLvl goes 1->0 latches W = lowCnt. Classification is registered, so strobes appear 2 cycles after the first above-threshold sample is on analogValue.
- Classification of W:
  - HS_MIN <= W <= HS_MAX: line sync. hsync=1 for one cycle. pixelX <= 0 in the same cycle. lineY increments (saturating). broadCnt clears.
  - W >= BROAD_MIN: broad pulse. broadCnt increments, saturating at BROAD_COUNT. On the transition to BROAD_COUNT: newFrame=1 for one cycle and lineY <= 0. Further broad pulses do not retrigger until broadCnt is cleared by a line sync.
  - Any other width: equalising pulse or noise. No strobe; broadCnt unchanged.
- pixelX: increments every cycle not cleared by hsync; saturates at 2047.
- Lock:
  - On each hsync, the period P = pixelX + 1 (clocks since the previous hsync). The very first hsync after reset or after lock loss only arms measurement.
  - |P - LINE_NOM| <= LINE_TOL: goodCnt increments, saturating at LOCK_LINES. locked=1 once goodCnt reaches LOCK_LINES, registered in the cycle after that hsync.
  - Bad P: goodCnt=0 and locked=0 in the next cycle.
  - pixelX reaching TIMEOUT: goodCnt=0, locked=0, measurement re-armed.
- Simultaneous events: hsync and newFrame are mutually exclusive by construction.
- A pulse still in progress when reset asserts is discarded. After reset deasserts, a sample already below threshold starts a fresh lowCnt; no strobe is emitted for a pulse whose start was not seen.

Optional Feature:
- SYNC_GLITCH_FILTER_EN defined:
  - syncLvl changes only after 2 consecutive raw compare results agree, which suppresses single-sample noise spikes.
  - All strobes are delayed 1 extra cycle (3 cycles total). Measured widths are unchanged for clean pulses.
- Undefined: raw single-stage compare as above, latency 2.

Test Plan:
- Samples at 20, with 75-clock pulses at level 0 every 1024 clocks, for 10 lines: hsync every 1024 clocks, 2 cycles after each pulse ends. pixelX reads 1023 the cycle before each hsync. locked rises on the 9th hsync (8th good period).
- PAL field pattern: 5 equalising (38 clk), 5 broad (437 clk), 5 equalising, then line syncs: exactly one newFrame, at the end of the 3rd broad pulse. lineY=0 there, then 1, 2, ... on subsequent hsyncs.
- Pulse widths 47, 48, 110, 111 and 299 clocks: hsync only for 48 and 110. No broadCnt change for 47, 111 and 299.
- After lock, one line at period 1100: locked drops the cycle after that hsync. 8 more nominal lines re-lock.
- After lock, input held at 20 for 3000 clocks: locked=0 when pixelX hits 2047. pixelX stays saturated at 2047, and lineY does not change.
- Reset asserted mid-pulse (60 clocks into a 75-clock sync): outputs 0 during reset, no hsync for that pulse. Normal hsync on the next full pulse.
- With SYNC_GLITCH_FILTER_EN, a single-sample level-0 spike on a level-20 line: no effect on lowCnt or strobes. Normal hsync latency is 3.
